// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and FSM encoding for the 3x3 convolution window feeder.
package conv_pkg;
   localparam int DATA_W   = 8;
   localparam int PROD_W   = 16;
   localparam int NUM_TAPS = 9;
   localparam int SUM_W    = 20;

   typedef enum logic [1:0] {IDLE, FILL, EMIT, DRAIN} state_t;
endpackage

// File: rtl/conv3x3_window_feeder_if.sv
// conv3x3_window_feeder_if: weight-load port, pixel stream in, partial-product bus out.
interface conv3x3_window_feeder_if;
   import conv_pkg::*;

   logic                w_load;
   logic [3:0]          w_idx;
   logic [DATA_W-1:0]   w_data;
   logic                pix_valid;
   logic                pix_ready;
   logic                pix_sof;
   logic [DATA_W-1:0]   pix_data;
   logic [PROD_W-1:0]   pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, pp9;
   logic                pp_valid;
   logic                pp_ready;
   logic                frame_done;

   modport slave (
      input  w_load, w_idx, w_data, pix_valid, pix_sof, pix_data, pp_ready,
      output pix_ready, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, pp9, pp_valid, frame_done
   );

   modport master (
      output w_load, w_idx, w_data, pix_valid, pix_sof, pix_data, pp_ready,
      input  pix_ready, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, pp9, pp_valid, frame_done
   );
endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of storage. Writes are clocked; the read port
// returns the pre-write contents of the addressed entry in the same cycle, so a
// column can be read out and replaced by the incoming pixel in a single handshake.
module conv_line_buffer #(
   parameter int DEPTH = 28,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign rdata_o = mem_q[addr_i];

   // Store the new entry at the addressed column
   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end
endmodule

// File: rtl/conv3x3_window_feeder.sv
// conv3x3_window_feeder: raster pixel stream -> 3x3 sliding window -> nine
// weighted 16-bit products, one fully populated window per output handshake.
module conv3x3_window_feeder
   import conv_pkg::*;
#(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic clk,
   input  logic rst,
   conv3x3_window_feeder_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   // Full-precision 8x8 unsigned multiply; 255*255 still fits 16 bits
   function automatic logic [PROD_W-1:0] tap_product(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
      return PROD_W'(a) * PROD_W'(b);
   endfunction

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d, col_eff;
   logic [RW-1:0]     row_q, row_d, row_eff;
   logic [DATA_W-1:0] wgt_q [NUM_TAPS];
   logic [DATA_W-1:0] win_q [3][3];
   logic [DATA_W-1:0] newcol [3];
   logic [DATA_W-1:0] tap [NUM_TAPS];
   logic [DATA_W-1:0] lb0_rd, lb1_rd;
   logic [PROD_W-1:0] pp_q [NUM_TAPS];
   logic              pp_valid_q, pp_valid_d, frame_done_q;
   logic              pix_ready, pix_hs, pp_hs, advance, win_done, last_pix;

   // Handshakes and the raster position the current pixel lands on (sof forces 0,0)
   always_comb begin
      pix_hs   = bus.pix_valid & pix_ready;
      pp_hs    = pp_valid_q & bus.pp_ready;
      advance  = pix_hs & ((state_q != IDLE) | bus.pix_sof);
      col_eff  = bus.pix_sof ? '0 : col_q;
      row_eff  = bus.pix_sof ? '0 : row_q;
      win_done = advance & (row_eff >= RW'(2)) & (col_eff >= CW'(2));
      last_pix = advance & (row_eff == ROW_LAST) & (col_eff == COL_LAST);
   end

   // Next raster position after an accepted pixel
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (advance) begin
         if (col_eff == COL_LAST) begin
            col_d = '0;
            row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
         end else begin
            col_d = col_eff + 1'b1;
            row_d = row_eff;
         end
      end
   end

   // FSM state and raster counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   // FSM next state: a sof mid-frame restarts filling, the final pixel drains
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (advance) state_d = FILL;
         FILL, EMIT: if (advance) begin
            if (bus.pix_sof)   state_d = FILL;
            else if (last_pix) state_d = DRAIN;
            else if (win_done) state_d = EMIT;
         end
         DRAIN:      if (pp_hs) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // FSM outputs: accept pixels unless draining or the output slot is blocked
   always_comb begin
      pix_ready = ~rst & (state_q != DRAIN) & (~pp_valid_q | bus.pp_ready);
   end

   // Weight register file, writable only between frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_TAPS; k++) wgt_q[k] <= '0;
      end else if ((state_q == IDLE) && bus.w_load && (bus.w_idx <= 4'd8)) begin
         wgt_q[bus.w_idx] <= bus.w_data;
      end
   end

   // lb0 holds the previous row, lb1 the row before; lb1 is refilled from lb0
   conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
      .clk(clk), .we_i(advance), .addr_i(col_eff), .wdata_i(bus.pix_data), .rdata_o(lb0_rd)
   );
   conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
      .clk(clk), .we_i(advance), .addr_i(col_eff), .wdata_i(lb0_rd), .rdata_o(lb1_rd)
   );

   // Window as it will look after this pixel: two kept columns plus the new one
   always_comb begin
      newcol[0] = lb1_rd;
      newcol[1] = lb0_rd;
      newcol[2] = bus.pix_data;
      for (int r = 0; r < 3; r++) begin
         tap[3*r]   = win_q[r][1];
         tap[3*r+1] = win_q[r][2];
         tap[3*r+2] = newcol[r];
      end
   end

   // Shift the window left by one column on every accepted pixel
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
            win_q[r][2] <= newcol[r];
         end
      end
   end

   assign pp_valid_d = win_done | (pp_valid_q & ~bus.pp_ready);

   // Output register: reload on a complete window, hold while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_TAPS; k++) pp_q[k] <= '0;
         pp_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         if (win_done) begin
            for (int k = 0; k < NUM_TAPS; k++) pp_q[k] <= tap_product(tap[k], wgt_q[k]);
         end
         pp_valid_q   <= pp_valid_d;
         frame_done_q <= (state_q == DRAIN) & pp_hs;
      end
   end

   assign bus.pix_ready  = pix_ready;
   assign bus.pp_valid   = pp_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.pp1 = pp_q[0];
   assign bus.pp2 = pp_q[1];
   assign bus.pp3 = pp_q[2];
   assign bus.pp4 = pp_q[3];
   assign bus.pp5 = pp_q[4];
   assign bus.pp6 = pp_q[5];
   assign bus.pp7 = pp_q[6];
   assign bus.pp8 = pp_q[7];
   assign bus.pp9 = pp_q[8];
endmodule

// File: tb/tb_conv3x3_window_feeder.sv
// tb_conv3x3_window_feeder: 4x4-frame bench for the window feeder with a
// frame-array reference model and a queue of expected windows.
module tb_conv3x3_window_feeder;
   localparam int W = 4;
   localparam int H = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   conv3x3_window_feeder_if bus ();

   conv3x3_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic             last;
      logic [8:0][15:0] p;
   } win_t;

   win_t             q[$];
   int               n_pass, n_chk;
   int               mw[9];
   int               img[H][W];
   int               pos;
   bit               in_frame, fd_exp, rand_pr, cap_first, sum_chk;
   int               out_cnt, fd_cnt, stall_cnt;
   logic [8:0][15:0] first_pp;
   logic [8:0][15:0] ppv;
   int               t1_exp[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

   assign ppv = {bus.pp9, bus.pp8, bus.pp7, bus.pp6, bus.pp5, bus.pp4, bus.pp3, bus.pp2, bus.pp1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: place the pixel in the frame array; a full 3x3 neighbourhood yields a window
   task automatic model_pix(input logic [7:0] d, input logic s);
      win_t it;
      int r, c;
      if (s) begin
         pos = 0;
         in_frame = 1;
      end
      if (!in_frame) return;
      r = pos / W;
      c = pos % W;
      img[r][c] = d;
      if (r >= 2 && c >= 2) begin
         it.last = (pos == W*H - 1);
         for (int k = 0; k < 9; k++) it.p[k] = 16'(img[r-2+k/3][c-2+k%3] * mw[k]);
         q.push_back(it);
      end
      pos++;
      if (pos == W*H) in_frame = 0;
   endtask

   // One clock: drive at negedge, check settled outputs, account handshakes
   task automatic cycle(input logic v, input logic [7:0] d, input logic s, input logic wl,
                        input logic [3:0] wi, input logic [7:0] wd, output bit acc);
      logic pr;
      bit   pix_hs, pp_hs, idle;
      win_t it;
      int   sum;
      pr = 1'b1;
      if (stall_cnt > 0) begin
         pr = 1'b0;
         stall_cnt--;
      end else if (rand_pr) begin
         pr = ($urandom_range(0, 2) != 0);
      end
      bus.pix_valid = v;
      bus.pix_data  = d;
      bus.pix_sof   = s;
      bus.pp_ready  = pr;
      bus.w_load    = wl;
      bus.w_idx     = wi;
      bus.w_data    = wd;
      #1;
      chk("pp_valid", bus.pp_valid, q.size() > 0);
      chk("pix_ready", bus.pix_ready, !(q.size() > 0 && q[0].last) && (q.size() == 0 || pr));
      chk("frame_done", bus.frame_done, fd_exp);
      if (bus.frame_done) fd_cnt++;
      if (q.size() > 0)
         for (int k = 0; k < 9; k++) chk($sformatf("pp%0d", k + 1), ppv[k], q[0].p[k]);
      pix_hs = v && bus.pix_ready;
      pp_hs  = bus.pp_valid && pr;
      idle   = !in_frame && !(q.size() > 0 && q[0].last);
      if (wl && idle && wi <= 4'd8) mw[wi] = wd;
      fd_exp = 0;
      if (pp_hs && q.size() > 0) begin
         it = q.pop_front();
         out_cnt++;
         fd_exp = it.last;
         if (cap_first && out_cnt == 1) first_pp = ppv;
         if (sum_chk) begin
            sum = 0;
            for (int k = 0; k < 9; k++) sum += ppv[k];
            chk("tree_sum", sum, 32'h8EE09);
         end
      end
      if (pix_hs) model_pix(d, s);
      acc = pix_hs;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_cyc();
      bit acc;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, acc);
   endtask

   task automatic wload(input logic [3:0] i, input logic [7:0] d);
      bit acc;
      cycle(1'b0, 8'h00, 1'b0, 1'b1, i, d, acc);
   endtask

   task automatic send(input logic [7:0] d, input logic s);
      bit acc;
      acc = 0;
      for (int i = 0; i < 40 && !acc; i++) cycle(1'b1, d, s, 1'b0, 4'd0, 8'h00, acc);
      if (!acc) chk("accept_timeout", acc, 1);
   endtask

   // mode 0 ramp, 1 all 255, 2 random; stall_at starts a 5-cycle pp_ready drop
   task automatic frame(input int mode, input int npix, input int stall_at);
      for (int i = 0; i < npix; i++) begin
         logic [7:0] d;
         d = (mode == 0) ? 8'(i) : (mode == 1) ? 8'hFF : 8'($urandom);
         if (i == stall_at) stall_cnt = 5;
         if (rand_pr && $urandom_range(0, 3) == 0) idle_cyc();
         send(d, i == 0);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (q.size() > 0 || fd_exp); i++) idle_cyc();
      chk("drain_empty", q.size(), 0);
      idle_cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_pp_valid", bus.pp_valid, 0);
      chk("rst_pix_ready", bus.pix_ready, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      for (int k = 0; k < 9; k++) chk($sformatf("rst_pp%0d", k + 1), ppv[k], 0);
      q.delete();
      in_frame  = 0;
      pos       = 0;
      fd_exp    = 0;
      stall_cnt = 0;
      for (int k = 0; k < 9; k++) mw[k] = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_pix_ready", bus.pix_ready, 1);
      @(negedge clk);
   endtask

   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_data  = 8'h00;
      bus.pix_sof   = 1'b0;
      bus.pp_ready  = 1'b1;
      bus.w_load    = 1'b0;
      bus.w_idx     = 4'd0;
      bus.w_data    = 8'h00;
      n_pass = 0; n_chk = 0; out_cnt = 0; fd_cnt = 0; stall_cnt = 0;
      rand_pr = 0; cap_first = 0; sum_chk = 0; fd_exp = 0;
      @(negedge clk);
      do_reset();

      // Ramp 0..15 with unit weights: four windows, one frame_done
      for (int k = 0; k < 9; k++) wload(4'(k), 8'd1);
      out_cnt = 0; fd_cnt = 0; cap_first = 1;
      frame(0, 16, -1);
      drain();
      cap_first = 0;
      for (int k = 0; k < 9; k++) chk($sformatf("t1_first_pp%0d", k + 1), first_pp[k], t1_exp[k]);
      chk("t1_out_cnt", out_cnt, 4);
      chk("t1_fd_cnt", fd_cnt, 1);

      // Worst case: every product 0xFE01, tree sum 0x8EE09
      for (int k = 0; k < 9; k++) wload(4'(k), 8'hFF);
      sum_chk = 1;
      frame(1, 16, -1);
      drain();
      sum_chk = 0;

      // Random weights, ramp with a 5-cycle output stall mid-frame
      for (int k = 0; k < 9; k++) wload(4'(k), 8'($urandom));
      frame(0, 16, 11);
      drain();

      // Weight write during EMIT is ignored; in IDLE it lands (idx 9 never does)
      for (int k = 0; k < 9; k++) wload(4'(k), 8'd1);
      for (int i = 0; i < 16; i++) begin
         if (i == 12) wload(4'd3, 8'd7);
         send(8'(i + 20), i == 0);
      end
      drain();
      wload(4'd3, 8'd7);
      wload(4'd9, 8'h55);
      frame(0, 16, -1);
      drain();

      // Non-sof pixels dropped in IDLE; sof mid-EMIT restarts with a window pending
      send(8'hAA, 1'b0);
      send(8'h55, 1'b0);
      for (int i = 0; i < 12; i++) send(8'($urandom), i == 0);
      stall_cnt = 2;
      frame(2, 16, -1);
      drain();

      // Random backpressure and bubbles over several random frames
      rand_pr = 1;
      for (int k = 0; k < 9; k++) wload(4'(k), 8'($urandom));
      for (int f = 0; f < 3; f++) frame(2, 16, -1);
      drain();
      rand_pr = 0;

      // Reset in EMIT with a window held, then weights are all zero
      for (int i = 0; i < 11; i++) send(8'(i + 1), i == 0);
      stall_cnt = 2;
      idle_cyc();
      do_reset();
      frame(2, 16, -1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
